pir_motion_ctrl: RTL and testbench

Parametrised multi-channel PIR motion controller; the successor to the single-channel blink-on-motion block. For each channel it:
- synchronises the raw PIR input,
- debounces it with a qualification window,
- applies a retriggerable hold-off timer,
- drives an indicator LED in either steady or blink mode.

It also produces per-channel one-cycle event pulses and a saturating global event counter for the status/telemetry logic.

---
 rtl/pir_motion_ctrl.sv | 112 +++++++++++
 tb/tb_pir_motion_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pir_motion_ctrl.sv
// pir_motion_ctrl: multi-channel PIR sync/debounce/hold-off with LED drive and saturating event counter
module pir_motion_ctrl #(
  parameter int NCH         = 4,
  parameter int DEB_CYCLES  = 12000,
  parameter int HOLD_CYCLES = 48000000,
  parameter int BLINK_HALF  = 12000000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   pir_in,
  input  logic             enable,
  input  logic             blink_mode,
  input  logic             cnt_clr,
  output logic [NCH-1:0]   led,
  output logic [NCH-1:0]   motion_active,
  output logic [NCH-1:0]   event_pulse,
  output logic             any_motion,
  output logic [CNT_W-1:0] event_count
);
  localparam int QW = $clog2(DEB_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int BW = $clog2(BLINK_HALF) + 1;
  localparam int SW = CNT_W + $clog2(NCH + 1);
  typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, HOLD} state_t;
  state_t         st [NCH];
  state_t         st_n [NCH];
  logic [QW-1:0]  qcnt [NCH];
  logic [QW-1:0]  qcnt_n [NCH];
  logic [HW-1:0]  hcnt [NCH];
  logic [HW-1:0]  hcnt_n [NCH];
  logic [NCH-1:0] s1, s, pulse_n;
  logic [BW-1:0]  bcnt;
  logic           phase, wrap;
  logic [SW-1:0]  sum;
  assign wrap = bcnt == BW'(BLINK_HALF - 1);
  assign any_motion = |motion_active;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s           <= '0;
      bcnt        <= '0;
      phase       <= 1'b0;
      led         <= '0;
      event_pulse <= '0;
      event_count <= '0;
      for (int i = 0; i < NCH; i++) begin
        st[i]   <= IDLE;
        qcnt[i] <= '0;
        hcnt[i] <= '0;
      end
    end else begin
      s1          <= pir_in;
      s           <= s1;
      bcnt        <= wrap ? '0 : bcnt + 1'b1;
      phase       <= phase ^ wrap;
      led         <= blink_mode ? motion_active & {NCH{phase}} : motion_active;
      event_pulse <= pulse_n;
      event_count <= cnt_clr ? '0 : (|sum[SW-1:CNT_W] ? '1 : sum[CNT_W-1:0]);
      for (int i = 0; i < NCH; i++) begin
        st[i]   <= st_n[i];
        qcnt[i] <= qcnt_n[i];
        hcnt[i] <= hcnt_n[i];
      end
    end
  end
  always_comb begin
    sum = SW'(event_count);
    for (int i = 0; i < NCH; i++) sum = sum + SW'(event_pulse[i]);
  end
  always_comb begin
    pulse_n       = '0;
    motion_active = '0;
    for (int i = 0; i < NCH; i++) begin
      st_n[i]   = st[i];
      qcnt_n[i] = qcnt[i];
      hcnt_n[i] = hcnt[i];
      motion_active[i] = st[i] == ACTIVE || st[i] == HOLD;
      if (!enable) begin
        st_n[i]   = IDLE;
        qcnt_n[i] = '0;
        hcnt_n[i] = '0;
      end else begin
        case (st[i])
          IDLE:
            if (s[i]) begin
              st_n[i]   = QUAL;
              qcnt_n[i] = QW'(1);
            end
          QUAL:
            if (!s[i]) begin
              st_n[i]   = IDLE;
              qcnt_n[i] = '0;
            end else if (qcnt[i] == QW'(DEB_CYCLES - 1)) begin
              st_n[i]    = ACTIVE;
              pulse_n[i] = 1'b1;
            end else qcnt_n[i] = qcnt[i] + 1'b1;
          ACTIVE:
            if (!s[i]) begin
              st_n[i]   = HOLD;
              hcnt_n[i] = '0;
            end
          HOLD:
            if (s[i]) st_n[i] = ACTIVE;
            else if (hcnt[i] == HW'(HOLD_CYCLES - 1)) st_n[i] = IDLE;
            else hcnt_n[i] = hcnt[i] + 1'b1;
          default: st_n[i] = IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pir_motion_ctrl.sv
// tb_pir_motion_ctrl: directed bench with an event scoreboard for pir_motion_ctrl
module tb_pir_motion_ctrl;
  logic       clk = 1'b0;
  logic       rst, enable, blink_mode, cnt_clr;
  logic [1:0] pir_in, led, motion_active, event_pulse;
  logic       any_motion;
  logic [2:0] event_count;
  int         cyc = 0, rel = 0, errors = 0, checks = 0;
  typedef struct {logic [1:0] mask; int at;} ev_t;
  ev_t sb[$];
  pir_motion_ctrl #(.NCH(2), .DEB_CYCLES(4), .HOLD_CYCLES(10), .BLINK_HALF(3), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .pir_in(pir_in), .enable(enable), .blink_mode(blink_mode),
    .cnt_clr(cnt_clr), .led(led), .motion_active(motion_active), .event_pulse(event_pulse),
    .any_motion(any_motion), .event_count(event_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_event(input logic [1:0] mask);
    sb.push_back('{mask: mask, at: cyc + 6});
  endtask
  always @(negedge clk) begin
    if (!rst && event_pulse !== 2'b00) begin
      if (sb.size() == 0) chk("unexpected_event", event_pulse, 2'b00);
      else begin
        ev_t e;
        e = sb.pop_front();
        chk("event_mask", event_pulse, e.mask);
        chk("event_edge", cyc, e.at);
      end
    end
  end
  initial begin
    rst = 1'b1; pir_in = 2'b11; enable = 1'b1; blink_mode = 1'b0; cnt_clr = 1'b0;
    step(3);
    chk("rst_led", led, 0);
    chk("rst_active", motion_active, 0);
    chk("rst_pulse", event_pulse, 0);
    chk("rst_any", any_motion, 0);
    chk("rst_count", event_count, 0);
    rst = 1'b0; pir_in = 2'b01; rel = cyc;
    expect_event(2'b01);
    step(5);
    chk("qual_not_yet", motion_active, 2'b00);
    step(1);
    chk("active_edge6", motion_active, 2'b01);
    chk("pulse_edge6", event_pulse, 2'b01);
    chk("any_edge6", any_motion, 1);
    chk("led_lag_edge6", led, 2'b00);
    step(1);
    chk("led_edge7", led, 2'b01);
    chk("pulse_one_cycle", event_pulse, 2'b00);
    chk("count_first", event_count, 1);
    pir_in = 2'b11;
    step(3);
    pir_in = 2'b01;
    step(10);
    chk("glitch_active", motion_active, 2'b01);
    chk("glitch_count", event_count, 1);
    pir_in = 2'b00;
    step(6);
    chk("hold_active", motion_active, 2'b01);
    pir_in = 2'b01;
    step(6);
    chk("retrigger_active", motion_active, 2'b01);
    chk("retrigger_count", event_count, 1);
    pir_in = 2'b00;
    step(12);
    chk("hold_edge12", motion_active, 2'b01);
    chk("hold_led_edge12", led, 2'b01);
    step(1);
    chk("hold_end_edge13", motion_active, 2'b00);
    chk("hold_any_edge13", any_motion, 0);
    chk("led_still_edge13", led, 2'b01);
    step(1);
    chk("led_off_edge14", led, 2'b00);
    pir_in = 2'b01;
    expect_event(2'b01);
    step(6);
    chk("blink_setup_active", motion_active, 2'b01);
    blink_mode = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk("blink_led", led, {1'b0, 1'(((cyc - rel - 1) / 3) % 2)});
    end
    blink_mode = 1'b0;
    step(1);
    chk("steady_led", led, 2'b01);
    pir_in = 2'b00;
    step(14);
    chk("both_idle", motion_active, 2'b00);
    chk("count_two", event_count, 2);
    pir_in = 2'b11;
    expect_event(2'b11);
    step(6);
    chk("dual_pulse", event_pulse, 2'b11);
    step(1);
    chk("dual_count", event_count, 4);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_count", event_count, 0);
    for (int r = 0; r < 9; r++) begin
      pir_in = 2'b00;
      step(14);
      pir_in = 2'b01;
      expect_event(2'b01);
      step(7);
      chk("sat_count", event_count, (r + 1 > 7) ? 7 : r + 1);
    end
    pir_in = 2'b00;
    step(14);
    pir_in = 2'b01;
    expect_event(2'b01);
    step(6);
    chk("clr_same_pulse", event_pulse, 2'b01);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_with_event", event_count, 0);
    step(1);
    chk("clr_event_dropped", event_count, 0);
    pir_in = 2'b00;
    step(5);
    chk("en_hold_active", motion_active, 2'b01);
    enable = 1'b0;
    step(1);
    chk("disable_active", motion_active, 2'b00);
    chk("disable_any", any_motion, 0);
    chk("disable_led_lag", led, 2'b01);
    step(1);
    chk("disable_led", led, 2'b00);
    enable = 1'b1; pir_in = 2'b01;
    expect_event(2'b01);
    step(5);
    chk("reen_qual", motion_active, 2'b00);
    step(1);
    chk("reen_active", motion_active, 2'b01);
    chk("reen_pulse", event_pulse, 2'b01);
    step(1);
    chk("reen_count", event_count, 1);
    step(3);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
